// File: rtl/turbo_bus_pkg.sv
// Shared constants and types for the turbo decoder bus <-> Avalon-ST converters.
package turbo_bus_pkg;

  localparam int ST                    = 8;
  localparam int ST_PER_BUS            = 512;
  localparam int NUM_ST_PER_BUS        = ST_PER_BUS / ST;
  localparam int NUM_BUS_PER_TURBO_PKT = 2;
  localparam int ST_PER_TURBO_PKT      = NUM_ST_PER_BUS * NUM_BUS_PER_TURBO_PKT;

  localparam int SYM_W  = $clog2(ST_PER_TURBO_PKT);
  localparam int BYTE_W = $clog2(NUM_ST_PER_BUS);
  localparam int WORD_W = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;

  typedef logic [ST_PER_BUS-1:0] bus_word_t;

  typedef enum logic {S_IDLE, S_STREAM} rd_state_t;

endpackage

// File: rtl/pkt_pingpong_bank.sv
// Two-bank packet storage: one bus-word write port, word-indexed combinational read.
module pkt_pingpong_bank
  import turbo_bus_pkg::*;
(
  input  logic                  clk_st,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [WORD_W-1:0]     wr_word,
  input  logic [ST_PER_BUS-1:0] wr_data,
  input  logic                  rd_bank,
  input  logic [WORD_W-1:0]     rd_word,
  output logic [ST_PER_BUS-1:0] rd_data
);

  // Contents survive reset; only the occupancy flags in the top are cleared.
  bus_word_t mem [2][NUM_BUS_PER_TURBO_PKT];

  always_ff @(posedge clk_st) begin
    if (wr_en) mem[wr_bank][wr_word] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_word];

endmodule

// File: rtl/bus2st_unpack.sv
// Unpacks 512-bit bus words into a byte-wide Avalon-ST turbo packet stream
// through a two-bank ping-pong buffer.
module bus2st_unpack
  import turbo_bus_pkg::*;
(
  input  logic                  clk_st,
  input  logic                  rst_n,
  input  logic [ST_PER_BUS-1:0] bus_data,
  input  logic                  bus_en,
  output logic                  bus_ready,
  output logic [ST-1:0]         st_data,
  output logic                  st_valid,
  output logic                  st_sop,
  output logic                  st_eop,
  input  logic                  st_ready,
  output logic                  err_overflow
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_BUS_PER_TURBO_PKT - 1);
  localparam logic [SYM_W-1:0]  LAST_SYM  = SYM_W'(ST_PER_TURBO_PKT - 1);

  logic [1:0]            full;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;
  logic                  run_q;
  logic                  wr_bank;
  logic [WORD_W-1:0]     wr_word;
  logic                  rd_bank;
  logic [SYM_W-1:0]      rd_sym;
  logic [WORD_W-1:0]     rd_word;
  logic [BYTE_W-1:0]     rd_byte;
  logic [ST_PER_BUS-1:0] rd_word_data;
  logic                  accept;
  logic                  wr_last;
  logic                  xfer;
  logic                  eop_xfer;
  rd_state_t             state;
  rd_state_t             state_nxt;

  // run_q keeps bus_ready low during reset without a path from rst_n.
  assign bus_ready = run_q & ~full[wr_bank];
  assign accept    = bus_en & bus_ready;
  assign wr_last   = (wr_word == LAST_WORD);

  assign st_valid  = (state == S_STREAM);
  assign xfer      = st_valid & st_ready;
  assign eop_xfer  = xfer & (rd_sym == LAST_SYM);

  assign full_set  = (accept & wr_last) ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr  = eop_xfer ? (2'b01 << rd_bank) : 2'b00;

  assign rd_word   = WORD_W'(rd_sym >> BYTE_W);
  assign rd_byte   = rd_sym[BYTE_W-1:0];

  assign st_data   = st_valid ? rd_word_data[int'(rd_byte) * ST +: ST] : '0;
  assign st_sop    = st_valid & (rd_sym == '0);
  assign st_eop    = st_valid & (rd_sym == LAST_SYM);

  pkt_pingpong_bank u_bank (
    .clk_st  (clk_st),
    .wr_en   (accept),
    .wr_bank (wr_bank),
    .wr_word (wr_word),
    .wr_data (bus_data),
    .rd_bank (rd_bank),
    .rd_word (rd_word),
    .rd_data (rd_word_data)
  );

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      wr_bank      <= 1'b0;
      wr_word      <= '0;
      full         <= '0;
      err_overflow <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (bus_en && !bus_ready) err_overflow <= 1'b1;
      if (accept) begin
        if (wr_last) begin
          wr_bank <= ~wr_bank;
          wr_word <= '0;
        end else begin
          wr_word <= wr_word + WORD_W'(1);
        end
      end
      // Set and clear always target different banks, so both may apply together.
      full <= (full | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_bank <= 1'b0;
      rd_sym  <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        if (eop_xfer) begin
          rd_sym  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_sym <= rd_sym + SYM_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (full[rd_bank]) state_nxt = S_STREAM;
      S_STREAM: if (eop_xfer)      state_nxt = full[~rd_bank] ? S_STREAM : S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

endmodule
